// File: rtl/fir_multichannel_if.sv
// Frame, handshake and coefficient-load signals of the multichannel FIR.
// master drives frames and coefficients; slave is the filter.
interface fir_multichannel_if #(
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned TAPS       = 16,
   parameter int unsigned COEF_WIDTH = 16
);
   logic [CHANNELS*WIDTH-1:0] in;
   logic                      input_ready;
   logic [CHANNELS*WIDTH-1:0] out;
   logic                      output_ready;
   logic                      busy;
   logic                      overrun;
   logic                      coef_we;
   logic [$clog2(TAPS)-1:0]   coef_addr;
   logic [COEF_WIDTH-1:0]     coef_data;

   modport master (
      output in, input_ready, coef_we, coef_addr, coef_data,
      input  out, output_ready, busy, overrun
   );

   modport slave (
      input  in, input_ready, coef_we, coef_addr, coef_data,
      output out, output_ready, busy, overrun
   );
endinterface

// File: rtl/fir_multichannel.sv
// Multichannel FIR: one time-multiplexed MAC filters every channel with shared, loadable taps.
// Define FIR_ROUND_EN for round-half-up before saturation; otherwise results are floored.
module fir_multichannel #(
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned TAPS       = 16,
   parameter int unsigned COEF_WIDTH = 16,
   parameter int unsigned COEF_FRAC  = 14
) (
   input  logic                ck,
   input  logic                rst,
   fir_multichannel_if.slave   fir_bus
);
   localparam int unsigned TapW = $clog2(TAPS);
   localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned AccW = WIDTH + COEF_WIDTH + TapW;

   typedef logic signed [WIDTH-1:0]      sample_t;
   typedef logic signed [COEF_WIDTH-1:0] coef_t;
   typedef enum logic [0:0] {StIdle, StMac} state_e;

`ifdef FIR_ROUND_EN
   localparam bit RoundEn = 1'b1;
`else
   localparam bit RoundEn = 1'b0;
`endif

   localparam logic signed [AccW:0] RndConst =
      (RoundEn && COEF_FRAC > 0) ? (AccW+1)'(1 << (COEF_FRAC - 1)) : '0;
   localparam logic signed [AccW:0] SatMax = (AccW+1)'((1 << (WIDTH - 1)) - 1);
   localparam logic signed [AccW:0] SatMin = -SatMax - 1;
   localparam coef_t               CoefOne = coef_t'(1 << COEF_FRAC);
   localparam logic [TapW-1:0]     TapLast = TapW'(TAPS - 1);
   localparam logic [ChW-1:0]      ChLast  = ChW'(CHANNELS - 1);

   state_e                    state_q, state_d;
   sample_t                   dly_q   [CHANNELS][TAPS];
   sample_t                   dly_d   [CHANNELS][TAPS];
   coef_t                     coef_q  [TAPS];
   coef_t                     coef_d  [TAPS];
   sample_t                   stage_q [CHANNELS];
   sample_t                   stage_d [CHANNELS];
   logic signed [AccW-1:0]    acc_q, acc_d;
   logic [ChW-1:0]            ch_q, ch_d;
   logic [TapW-1:0]           tap_q, tap_d;
   logic [CHANNELS*WIDTH-1:0] out_q, out_d;
   logic                      out_rdy_q, out_rdy_d;
   logic                      busy_q, busy_d;
   logic                      overrun_q, overrun_d;

   sample_t                   mac_smp;
   coef_t                     mac_coef;
   logic signed [AccW-1:0]    mac_prod, mac_sum;
   logic signed [AccW:0]      rnd_sum, shifted;
   sample_t                   sat_res;

   // Datapath: current product, running sum and the scaled, saturated channel result.
   always_comb begin
      mac_smp  = dly_q[ch_q][tap_q];
      mac_coef = coef_q[tap_q];
      mac_prod = AccW'(mac_smp) * AccW'(mac_coef);
      mac_sum  = acc_q + mac_prod;
      rnd_sum  = {mac_sum[AccW-1], mac_sum} + RndConst;
      shifted  = rnd_sum >>> COEF_FRAC;
      if (shifted > SatMax) begin
         sat_res = SatMax[WIDTH-1:0];
      end else if (shifted < SatMin) begin
         sat_res = SatMin[WIDTH-1:0];
      end else begin
         sat_res = shifted[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      dly_d     = dly_q;
      coef_d    = coef_q;
      stage_d   = stage_q;
      acc_d     = acc_q;
      ch_d      = ch_q;
      tap_d     = tap_q;
      out_d     = out_q;
      out_rdy_d = 1'b0;
      busy_d    = busy_q;
      overrun_d = 1'b0;

      // Coefficients only change between sequences, so a frame never sees a mixed set.
      if (fir_bus.coef_we && state_q == StIdle && 32'(fir_bus.coef_addr) < TAPS) begin
         coef_d[fir_bus.coef_addr] = coef_t'(fir_bus.coef_data);
      end

      unique case (state_q)
         StIdle: begin
            if (fir_bus.input_ready) begin
               for (int c = 0; c < CHANNELS; c++) begin
                  for (int k = TAPS - 1; k > 0; k--) begin
                     dly_d[c][k] = dly_q[c][k-1];
                  end
                  dly_d[c][0] = sample_t'(fir_bus.in[c*WIDTH +: WIDTH]);
               end
               acc_d   = '0;
               ch_d    = '0;
               tap_d   = '0;
               busy_d  = 1'b1;
               state_d = StMac;
            end
         end
         StMac: begin
            overrun_d = fir_bus.input_ready;
            acc_d     = mac_sum;
            tap_d     = tap_q + TapW'(1);
            if (tap_q == TapLast) begin
               stage_d[ch_q] = sat_res;
               acc_d         = '0;
               tap_d         = '0;
               ch_d          = ch_q + ChW'(1);
               if (ch_q == ChLast) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     out_d[c*WIDTH +: WIDTH] = stage_d[c];
                  end
                  ch_d      = '0;
                  out_rdy_d = 1'b1;
                  busy_d    = 1'b0;
                  state_d   = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state_q   <= StIdle;
         dly_q     <= '{default: '0};
         coef_q    <= '{default: '0};
         coef_q[0] <= CoefOne;
         stage_q   <= '{default: '0};
         acc_q     <= '0;
         ch_q      <= '0;
         tap_q     <= '0;
         out_q     <= '0;
         out_rdy_q <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dly_q     <= dly_d;
         coef_q    <= coef_d;
         stage_q   <= stage_d;
         acc_q     <= acc_d;
         ch_q      <= ch_d;
         tap_q     <= tap_d;
         out_q     <= out_d;
         out_rdy_q <= out_rdy_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign fir_bus.out          = out_q;
   assign fir_bus.output_ready = out_rdy_q;
   assign fir_bus.busy         = busy_q;
   assign fir_bus.overrun      = overrun_q;
endmodule

// File: tb/tb_fir_multichannel.sv
// Directed bench for fir_multichannel at default parameters (2 channels, 16 taps, Q2.14).
module tb_fir_multichannel;
   logic ck = 1'b0;
   logic rst;

   fir_multichannel_if bus_if ();

   fir_multichannel dut (
      .ck     (ck),
      .rst    (rst),
      .fir_bus(bus_if)
   );

   always #5 ck = ~ck;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // All tasks start and end on a falling edge of ck.
   task automatic do_reset();
      rst = 1'b1;
      @(negedge ck);
      @(negedge ck);
      rst = 1'b0;
   endtask

   task automatic write_coef(input logic [3:0] addr, input logic [15:0] data);
      bus_if.coef_we   = 1'b1;
      bus_if.coef_addr = addr;
      bus_if.coef_data = data;
      @(negedge ck);
      bus_if.coef_we   = 1'b0;
   endtask

   task automatic start_frame(input logic [15:0] c0, input logic [15:0] c1);
      bus_if.in          = {c1, c0};
      bus_if.input_ready = 1'b1;
      @(negedge ck);
      bus_if.input_ready = 1'b0;
   endtask

   // Counts falling edges from the one after acceptance until output_ready is seen.
   task automatic wait_done(output int lat, output int busy_cnt, output int ovr_cnt);
      lat = 0;
      busy_cnt = 0;
      ovr_cnt = 0;
      while (!bus_if.output_ready && lat < 200) begin
         if (bus_if.busy) busy_cnt++;
         if (bus_if.overrun) ovr_cnt++;
         @(negedge ck);
         lat++;
      end
   endtask

   int lat, bcnt, ocnt, pulses;
   logic [15:0] exp_lo, exp_neg;

   initial begin
      rst                = 1'b1;
      bus_if.in          = '0;
      bus_if.input_ready = 1'b0;
      bus_if.coef_we     = 1'b0;
      bus_if.coef_addr   = '0;
      bus_if.coef_data   = '0;
      repeat (3) @(negedge ck);
      rst = 1'b0;

      check_eq("reset_out", bus_if.out, 32'h0);
      check_eq("reset_oready", bus_if.output_ready, 1'b0);
      check_eq("reset_busy", bus_if.busy, 1'b0);
      check_eq("reset_overrun", bus_if.overrun, 1'b0);

      // Default coefficients pass samples straight through.
      start_frame(16'h1234, 16'hFEDC);
      wait_done(lat, bcnt, ocnt);
      check_eq("pass_latency", lat, 32);
      check_eq("pass_busy_cycles", bcnt, 32);
      check_eq("pass_ch0", bus_if.out[15:0], 16'h1234);
      check_eq("pass_ch1", bus_if.out[31:16], 16'hFEDC);
      @(negedge ck);
      check_eq("pass_oready_width", bus_if.output_ready, 1'b0);
      check_eq("pass_out_hold", bus_if.out, 32'hFEDC_1234);

      // Impulse of 1.0 walks out each coefficient in turn.
      do_reset();
      for (int k = 0; k < 16; k++) write_coef(4'(k), 16'(16'h0100 * (k + 1)));
      for (int j = 0; j < 16; j++) begin
         start_frame((j == 0) ? 16'h4000 : 16'h0000, 16'h0000);
         wait_done(lat, bcnt, ocnt);
         check_eq($sformatf("impulse_ch0_%0d", j), bus_if.out[15:0], 16'(16'h0100 * (j + 1)));
         check_eq($sformatf("impulse_ch1_%0d", j), bus_if.out[31:16], 16'h0000);
      end

      do_reset();
      write_coef(4'd0, 16'h7FFF);
      start_frame(16'h7000, 16'h0000);
      wait_done(lat, bcnt, ocnt);
      check_eq("sat_pos", bus_if.out[15:0], 16'h7FFF);
      start_frame(16'h9000, 16'h0000);
      wait_done(lat, bcnt, ocnt);
      check_eq("sat_neg", bus_if.out[15:0], 16'h8000);

`ifdef FIR_ROUND_EN
      exp_lo  = 16'h0002;
      exp_neg = 16'hFFFF;
`else
      exp_lo  = 16'h0001;
      exp_neg = 16'hFFFE;
`endif
      do_reset();
      write_coef(4'd0, 16'h2000);
      start_frame(16'h0003, 16'h0000);
      wait_done(lat, bcnt, ocnt);
      check_eq("round_pos", bus_if.out[15:0], exp_lo);
      start_frame(16'hFFFD, 16'h0000);
      wait_done(lat, bcnt, ocnt);
      check_eq("round_neg", bus_if.out[15:0], exp_neg);

      // Taps 0 and 1 at 1.0 expose the delay-line history.
      do_reset();
      write_coef(4'd1, 16'h4000);
      start_frame(16'h0100, 16'h0000);
      repeat (4) @(negedge ck);
      bus_if.in          = {16'h0000, 16'h0222};
      bus_if.input_ready = 1'b1;
      bus_if.coef_we     = 1'b1;
      bus_if.coef_addr   = 4'd0;
      bus_if.coef_data   = 16'h0000;
      @(negedge ck);
      bus_if.input_ready = 1'b0;
      bus_if.coef_we     = 1'b0;
      check_eq("ovr_pulse", bus_if.overrun, 1'b1);
      wait_done(lat, bcnt, ocnt);
      check_eq("ovr_count", ocnt, 1);
      check_eq("ovr_first_frame", bus_if.out[15:0], 16'h0100);
      start_frame(16'h0300, 16'h0000);
      wait_done(lat, bcnt, ocnt);
      check_eq("ovr_next_frame", bus_if.out[15:0], 16'h0400);

      do_reset();
      start_frame(16'h0055, 16'h0011);
      repeat (9) @(negedge ck);
      rst = 1'b1;
      @(negedge ck);
      rst = 1'b0;
      check_eq("abort_out", bus_if.out, 32'h0);
      check_eq("abort_busy", bus_if.busy, 1'b0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus_if.output_ready) pulses++;
         @(negedge ck);
      end
      check_eq("abort_no_oready", pulses, 0);
      start_frame(16'h0042, 16'h0000);
      wait_done(lat, bcnt, ocnt);
      check_eq("abort_next_lat", lat, 32);
      check_eq("abort_next_ch0", bus_if.out[15:0], 16'h0042);
      // Issued in the output_ready cycle: must be accepted.
      start_frame(16'h0077, 16'h0123);
      wait_done(lat, bcnt, ocnt);
      check_eq("b2b_lat", lat, 32);
      check_eq("b2b_overrun", ocnt, 0);
      check_eq("b2b_ch0", bus_if.out[15:0], 16'h0077);
      check_eq("b2b_ch1", bus_if.out[31:16], 16'h0123);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
